// File: rtl/regfile_sb.sv
// Register file with async reset, optional hardwired zero register, write-to-read bypass
// and a per-register pending scoreboard that flags operands whose producer is in flight.
module regfile_sb #(
    parameter int unsigned  XLEN     = 32,
    parameter int unsigned  DEPTH    = 32,
    parameter bit           ZERO_REG = 1'b1,
    parameter bit           BYPASS   = 1'b1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            rbusy1,
    output logic            rbusy2,
    output logic            stall,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_addr,
    input  logic            RegWrite,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            flush,
    output logic [AW:0]     pending_cnt
);

    logic [XLEN-1:0] regs_q [DEPTH];
    logic [XLEN-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pending_q, pending_d;
    logic [AW:0]      cnt_q, cnt_d;

    logic we, iss, byp1, byp2, inc, dec;

    // Effective write/issue: register 0 is inert when hardwired to zero.
    assign we  = RegWrite && !(ZERO_REG && (waddr == '0));
    assign iss = issue_valid && !(ZERO_REG && (issue_addr == '0));

    always_comb begin
        byp1 = BYPASS && we && (waddr == raddr1);
        byp2 = BYPASS && we && (waddr == raddr2);

        if (ZERO_REG && (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (byp1) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs_q[raddr1];
        end

        if (ZERO_REG && (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (byp2) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs_q[raddr2];
        end

        rbusy1      = pending_q[raddr1] && !byp1;
        rbusy2      = pending_q[raddr2] && !byp2;
        stall       = rbusy1 || rbusy2;
        pending_cnt = cnt_q;
    end

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Issue is applied last so it overrides flush and a same-cycle retiring writeback.
    always_comb begin
        pending_d = flush ? '0 : pending_q;
        if (!flush && we) begin
            pending_d[waddr] = 1'b0;
        end
        if (iss) begin
            pending_d[issue_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            pending_d[0] = 1'b0;
        end
    end

    always_comb begin
        inc = iss && !pending_q[issue_addr];
        dec = !flush && we && pending_q[waddr] && !(iss && (issue_addr == waddr));
        if (flush) begin
            cnt_d = {{AW{1'b0}}, iss};
        end else begin
            cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: reference model feeds an expected-observation queue; a second
// instance without bypass is checked where forwarding behaviour matters.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    typedef struct packed {
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic            b1;
        logic            b2;
        logic            st;
        logic [AW:0]     cnt;
    } obs_t;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic [AW-1:0]   raddr1 = '0, raddr2 = '0, issue_addr = '0, waddr = '0;
    logic            issue_valid = 1'b0, RegWrite = 1'b0, flush = 1'b0;
    logic [XLEN-1:0] wdata = '0;

    logic [XLEN-1:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic            rbusy1, rbusy2, stall, nb_rbusy1, nb_rbusy2, nb_stall;
    logic [AW:0]     pending_cnt, nb_cnt;

    int   n_vec, n_err;
    obs_t exp_q[$];
    obs_t got, exp;

    logic [XLEN-1:0] m_reg [DEPTH];
    logic            m_pend [DEPTH];

    always #5 Clk = ~Clk;

    regfile_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .rbusy1(rbusy1), .rbusy2(rbusy2), .stall(stall),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .RegWrite(RegWrite),
        .waddr(waddr), .wdata(wdata), .flush(flush), .pending_cnt(pending_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .Clk(Clk), .Rst_n(Rst_n), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(nb_rdata1), .rdata2(nb_rdata2), .rbusy1(nb_rbusy1), .rbusy2(nb_rbusy2),
        .stall(nb_stall), .issue_valid(issue_valid), .issue_addr(issue_addr),
        .RegWrite(RegWrite), .waddr(waddr), .wdata(wdata), .flush(flush),
        .pending_cnt(nb_cnt)
    );

    function automatic logic [XLEN-1:0] model_rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (RegWrite && (waddr == a)) return wdata;
        return m_reg[a];
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        int   c = 0;
        o.d1 = model_rd(raddr1);
        o.d2 = model_rd(raddr2);
        o.b1 = m_pend[raddr1] && !(RegWrite && (waddr == raddr1));
        o.b2 = m_pend[raddr2] && !(RegWrite && (waddr == raddr2));
        o.st = o.b1 || o.b2;
        for (int i = 0; i < DEPTH; i++) if (m_pend[i]) c++;
        o.cnt = (AW+1)'(c);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.d1 = rdata1; o.d2 = rdata2; o.b1 = rbusy1; o.b2 = rbusy2; o.st = stall;
        o.cnt = pending_cnt;
        return o;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Rising edge: update the model from the inputs held across the edge, then return at negedge.
    task automatic tick();
        logic np [DEPTH];
        @(posedge Clk);
        if (Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == 0)                                         np[i] = 1'b0;
                else if (flush)                np[i] = issue_valid && (int'(issue_addr) == i);
                else if (issue_valid && (int'(issue_addr) == i))    np[i] = 1'b1;
                else if (RegWrite && (int'(waddr) == i))            np[i] = 1'b0;
                else                                                np[i] = m_pend[i];
            end
            if (RegWrite && (waddr != '0)) m_reg[waddr] = wdata;
            for (int i = 0; i < DEPTH; i++) m_pend[i] = np[i];
        end
        @(negedge Clk);
    endtask

    task automatic idle();
        issue_valid = 1'b0; RegWrite = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reset_initial got=%h exp=%h", got, exp); end
        Rst_n = 1'b1;
        @(negedge Clk);
        RegWrite = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        issue_valid = 1'b1; issue_addr = 5'd3; raddr1 = 5'd5; raddr2 = 5'd3;
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reset_load got=%h exp=%h", got, exp); end
        tick();
        idle();
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reset_pre got=%h exp=%h", got, exp); end
        n_vec++;
        if (rdata1 !== 32'hDEADBEEF || pending_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL reset_pre_const rdata1=%h cnt=%0d exp DEADBEEF/1", rdata1, pending_cnt);
        end
        #1; Rst_n = 1'b0; model_clear();
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reset_async got=%h exp=%h", got, exp); end
        n_vec++;
        if (rdata1 !== '0 || pending_cnt !== '0 || stall !== 1'b0 || nb_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_async_const rdata1=%h cnt=%0d stall=%b exp 0/0/0",
                     rdata1, pending_cnt, stall);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; waddr = '0; wdata = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_addr = '0; raddr1 = '0; raddr2 = '0;
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL zero_same got=%h exp=%h", got, exp); end
        tick();
        idle();
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL zero_next got=%h exp=%h", got, exp); end
        n_vec++;
        if (rdata1 !== '0 || rbusy1 !== 1'b0 || pending_cnt !== '0) begin
            n_err++;
            $display("FAIL zero_const rdata1=%h rbusy1=%b cnt=%0d exp 0/0/0",
                     rdata1, rbusy1, pending_cnt);
        end
        tick();
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        tick();
        wdata = 32'h12345678; raddr2 = 5'd7; raddr1 = 5'd5;
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL bypass_same got=%h exp=%h", got, exp); end
        n_vec++;
        if (rdata2 !== 32'h12345678 || nb_rdata2 !== 32'h11111111) begin
            n_err++;
            $display("FAIL bypass_const rdata2=%h nb_rdata2=%h exp 12345678/11111111",
                     rdata2, nb_rdata2);
        end
        tick();
        idle();
        n_vec++;
        #1;
        if (rdata2 !== 32'h12345678 || nb_rdata2 !== 32'h12345678) begin
            n_err++;
            $display("FAIL bypass_next rdata2=%h nb_rdata2=%h exp 12345678", rdata2, nb_rdata2);
        end
        tick();
    endtask

    task automatic test_hazard();
        issue_valid = 1'b1; issue_addr = 5'd3;
        tick();
        idle(); raddr1 = 5'd3; raddr2 = 5'd7;
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL hazard_busy got=%h exp=%h", got, exp); end
        n_vec++;
        if (rbusy1 !== 1'b1 || stall !== 1'b1 || pending_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL hazard_busy_const rbusy1=%b stall=%b cnt=%0d exp 1/1/1",
                     rbusy1, stall, pending_cnt);
        end
        RegWrite = 1'b1; waddr = 5'd3; wdata = 32'h000000A5;
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL hazard_wb got=%h exp=%h", got, exp); end
        n_vec++;
        if (rbusy1 !== 1'b0 || nb_rbusy1 !== 1'b1) begin
            n_err++;
            $display("FAIL hazard_wb_busy rbusy1=%b nb_rbusy1=%b exp 0/1", rbusy1, nb_rbusy1);
        end
        tick();
        idle();
        n_vec++;
        #1;
        if (rdata1 !== 32'h000000A5 || pending_cnt !== '0 || rbusy1 !== 1'b0) begin
            n_err++;
            $display("FAIL hazard_done rdata1=%h cnt=%0d rbusy1=%b exp A5/0/0",
                     rdata1, pending_cnt, rbusy1);
        end
        tick();
    endtask

    task automatic test_issue_wb();
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        RegWrite = 1'b1; waddr = 5'd9; wdata = 32'h00000099;
        tick();
        idle(); raddr1 = 5'd9;
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL issue_wb got=%h exp=%h", got, exp); end
        n_vec++;
        if (rbusy1 !== 1'b1 || rdata1 !== 32'h00000099 || pending_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL issue_wb_const rbusy1=%b rdata1=%h cnt=%0d exp 1/99/1",
                     rbusy1, rdata1, pending_cnt);
        end
        tick();
    endtask

    task automatic test_flush();
        issue_valid = 1'b1;
        issue_addr = 5'd1; tick();
        issue_addr = 5'd2; tick();
        issue_addr = 5'd4; tick();
        idle();
        n_vec++;
        #1;
        if (pending_cnt !== 6'd4) begin
            n_err++;
            $display("FAIL flush_pre cnt got=%0d exp=4", pending_cnt);
        end
        flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd6;
        tick();
        idle(); raddr1 = 5'd6; raddr2 = 5'd9;
        exp_q.push_back(model_obs());
        #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL flush_issue got=%h exp=%h", got, exp); end
        n_vec++;
        if (pending_cnt !== 6'd1 || rbusy1 !== 1'b1 || rbusy2 !== 1'b0) begin
            n_err++;
            $display("FAIL flush_const cnt=%0d rbusy1=%b rbusy2=%b exp 1/1/0",
                     pending_cnt, rbusy1, rbusy2);
        end
        flush = 1'b1;
        tick();
        idle();
        n_vec++;
        #1;
        if (pending_cnt !== '0 || rbusy1 !== 1'b0) begin
            n_err++;
            $display("FAIL flush_only cnt=%0d rbusy1=%b exp 0/0", pending_cnt, rbusy1);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            raddr1      = AW'($urandom_range(0, 7));
            raddr2      = AW'($urandom_range(0, DEPTH - 1));
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr  = AW'($urandom_range(0, 7));
            RegWrite    = 1'($urandom_range(0, 1));
            waddr       = AW'($urandom_range(0, 7));
            wdata       = $urandom;
            flush       = ($urandom_range(0, 19) == 0);
            exp_q.push_back(model_obs());
            #1; got = sample(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random[%0d] got=%h exp=%h", n, got, exp);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_clear();
        test_reset();
        test_zero_reg();
        test_bypass();
        test_hazard();
        test_issue_wb();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file. Adds async active-low reset, configurable width/depth, a hardwired-zero option, write-to-read bypass, and a per-register pending scoreboard.
- Sits between decode (reads plus destination issue) and writeback.
- Provides operand data plus a hazard indication for a pipelined core.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never marked pending.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  async active-low reset.
- raddr1  in  AW  read port 1 address.
- raddr2  in  AW  read port 2 address.
- rdata1  out  XLEN  read port 1 data (combinational).
- rdata2  out  XLEN  read port 2 data (combinational).
- rbusy1  out  1  raddr1 register pending and not satisfied by bypass.
- rbusy2  out  1  raddr2 register pending and not satisfied by bypass.
- stall  out  1  rbusy1 OR rbusy2.
- issue_valid  in  1  mark issue_addr pending (new producer in flight).
- issue_addr  in  AW  destination being issued.
- RegWrite  in  1  writeback enable.
- waddr  in  AW  writeback address.
- wdata  in  XLEN  writeback data.
- flush  in  1  clear all pending bits (pipeline squash).
- pending_cnt  out  AW+1  number of registers currently pending.

Behaviour:
- Reset: Rst_n low immediately clears all registers to 0, all pending bits to 0 and pending_cnt to 0. rdata1/rdata2 then reflect 0 and rbusy1/rbusy2/stall are 0. Reset mid-operation discards in-flight issues.
- Write: on posedge Clk, if RegWrite and not (ZERO_REG and waddr==0), then Reg[waddr] <= wdata. Visible on the read ports the following cycle.
- Read: rdataN = 0 if ZERO_REG and raddrN==0. Otherwise, if BYPASS and RegWrite and waddr==raddrN (and the write is not suppressed by ZERO_REG), rdataN = wdata. Otherwise rdataN = Reg[raddrN].
- Scoreboard, next state of pending[i], in priority order:
  - flush -> 0 for all i, except that issue_valid in the same cycle still sets pending[issue_addr] (the new producer post-flush).
  - else issue_valid and issue_addr==i -> 1. Issue wins over a same-cycle writeback to the same register; the older producer is retiring.
  - else RegWrite and waddr==i -> 0.
  - else hold.
  - ZERO_REG: pending[0] is always 0.
- Busy: rbusyN = pending[raddrN] AND NOT (BYPASS and RegWrite and waddr==raddrN). Combinational, same cycle.
- pending_cnt: registered population count of pending. Updated together with pending by the same-edge delta: +1 for an issue to a non-pending register, -1 for a clear, 0 when both apply to the same register. Never exceeds DEPTH (DEPTH-1 with ZERO_REG). After flush it equals issue_valid (0 or 1, subject to ZERO_REG).
- Writeback to a non-pending register is legal: it writes the data and does not change the scoreboard.
- Re-issue to an already-pending register keeps it pending with no count change.
- No X on outputs after reset; out-of-range addresses cannot occur (DEPTH is a power of two).

Test Plan:
- Reset: load r5=0xDEADBEEF, assert Rst_n=0 mid-cycle -> rdata for r5 reads 0 immediately; pending_cnt=0; stall=0.
- Zero register: RegWrite waddr=0 wdata=0xFFFFFFFF, issue_addr=0 -> rdata1 (raddr1=0) stays 0; pending_cnt stays 0; rbusy1=0.
- Bypass: RegWrite waddr=7 wdata=0x12345678, raddr2=7 in the same cycle -> rdata2=0x12345678 that cycle. With BYPASS=0 it reads the old value, then 0x12345678 the next cycle.
- Hazard lifecycle: issue r3 -> next cycle raddr1=3 gives rbusy1=1, stall=1, pending_cnt=1. Writeback r3=0xA5 -> rbusy1=0 in that cycle; next cycle pending_cnt=0 and rdata1=0xA5.
- Simultaneous issue and writeback to r9 (r9 pending) -> r9 stays pending, data updated, pending_cnt unchanged.
- Flush with issue: pend r1, r2, r4, then flush plus issue r6 -> next cycle only r6 pending and pending_cnt=1.
